// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift-out, ACK check.
// Optional build macro PS2_TX_RETRY_EN: up to two automatic re-sends after NACK or timeout.
//
// state     | meaning
// IDLE      | ready for a command byte, both lines released
// INHIBIT   | hold ps2_clk low; data pulled low in the final cycle
// RTS       | clock released, start bit (data low) driven
// SHIFT     | data/parity/stop presented on each device clock fall
// ACK       | lines released, sample device ACK on the next fall
// WAIT_IDLE | wait for clock and data high, then report result
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 60_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_CYC = 900_000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYC - 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [19:0] TO_LIM = 20'(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_RTS     = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;

  logic [1:0] sync1_q, sync2_q, filt;
  logic       clk_prev_q;
  logic       clk_filt, data_filt, clk_fall;

  always_ff @(posedge clk60MHz or negedge rst) begin
    if (!rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {ps2_data_in, ps2_clk_in};
      sync2_q <= sync1_q;
    end
  end

  // A new level is taken only after FILTER_LEN consecutive differing samples.
  for (genvar g = 0; g < 2; g++) begin : g_flt
    logic [FLT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;

    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync2_q[g] != lvl_q) begin
        if (cnt_q == FLT_LAST) lvl_d = sync2_q[g];
        else cnt_d = cnt_q + FLT_W'(1);
      end
    end

    always_ff @(posedge clk60MHz or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        lvl_q <= 1'b1;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign filt[g] = lvl_q;
  end

  assign clk_filt  = filt[0];
  assign data_filt = filt[1];

  always_ff @(posedge clk60MHz or negedge rst) begin
    if (!rst) clk_prev_q <= 1'b1;
    else      clk_prev_q <= clk_filt;
  end

  assign clk_fall = clk_prev_q & ~clk_filt;

  logic [2:0]       state_q, state_d;
  logic [10:0]      frame_q, frame_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [19:0]      to_cnt_q, to_cnt_d;
  logic             ack_ok_q, ack_ok_d;
  logic             timed, to_hit, done_c, fail_c, err_c;
`ifdef PS2_TX_RETRY_EN
  logic [7:0]       data_q, data_d;
  logic [1:0]       retry_q, retry_d;
`endif

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    ack_ok_d  = ack_ok_q;
    timed     = 1'b0;
    to_hit    = 1'b0;
    done_c    = 1'b0;
    fail_c    = 1'b0;
    err_c     = 1'b0;
`ifdef PS2_TX_RETRY_EN
    data_d    = data_q;
    retry_d   = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (tx_valid) begin
          // frame LSB first: start(0), data[7:0], odd parity, stop(1)
          frame_d   = {1'b1, ~^tx_data, tx_data, 1'b0};
          inh_cnt_d = INH_LOAD;
          bit_idx_d = '0;
          state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          data_d    = tx_data;
          retry_d   = '0;
`endif
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == '0) begin
          state_d  = S_RTS;
          to_cnt_d = '0;
        end else begin
          inh_cnt_d = inh_cnt_q - INH_W'(1);
        end
      end
      S_RTS: begin
        timed     = 1'b1;
        bit_idx_d = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        timed = 1'b1;
        if (clk_fall) begin
          if (bit_idx_q == 4'd10) begin
            state_d = S_ACK;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            frame_d   = {1'b1, frame_q[10:1]};
          end
        end
      end
      S_ACK: begin
        timed = 1'b1;
        if (clk_fall) begin
          ack_ok_d = ~data_filt;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        timed = 1'b1;
        if (clk_filt && data_filt) begin
          state_d = S_IDLE;
          if (ack_ok_q) done_c = 1'b1;
          else          fail_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timed) to_cnt_d = clk_fall ? 20'd0 : to_cnt_q + 20'd1;

    // A completed ACK/NACK in the same cycle takes precedence over the timeout.
    if (timed && (to_cnt_q == TO_LIM) && !done_c && !fail_c) begin
      to_hit  = 1'b1;
      fail_c  = 1'b1;
      state_d = S_IDLE;
    end

    if (fail_c) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d   = retry_q + 2'd1;
        frame_d   = {1'b1, ~^data_q, data_q, 1'b0};
        inh_cnt_d = INH_LOAD;
        bit_idx_d = '0;
        state_d   = S_INHIBIT;
      end else begin
        err_c = 1'b1;
      end
`else
      err_c = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk60MHz or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '1;
      bit_idx_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      ack_ok_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      data_q    <= '0;
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      ack_ok_q  <= ack_ok_d;
`ifdef PS2_TX_RETRY_EN
      data_q    <= data_d;
      retry_q   <= retry_d;
`endif
    end
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = ~tx_ready;
  assign rx_inhibit = busy;
  assign tx_done    = done_c;
  assign tx_err     = err_c;

  assign ps2_clk_oe  = (state_q == S_INHIBIT);
  assign ps2_data_oe = ~to_hit &
                       (((state_q == S_INHIBIT) && (inh_cnt_q == '0)) ||
                        (((state_q == S_RTS) || (state_q == S_SHIFT)) && !frame_q[0]));

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device on the open-drain lines.
// Builds with or without PS2_TX_RETRY_EN.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int CLK_HZ  = 1_000_000;
  localparam int INH_US  = 100;
  localparam int INH_CYC = 100;
  localparam int TO_CYC  = 3000;
  localparam int FLT     = 8;
  localparam int H       = 40;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif
  localparam int BUD = 25000;

  logic       clk60MHz, rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_done, tx_err, busy, rx_inhibit;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low, glitch_low;
  wire        ps2_clk_line  = ~ps2_clk_oe & ~dev_clk_low & ~glitch_low;
  wire        ps2_data_line = ~ps2_data_oe & ~dev_data_low;

  ps2_host_tx #(.CLK_FREQ_HZ(CLK_HZ), .INHIBIT_US(INH_US), .TIMEOUT_CYC(TO_CYC),
                .FILTER_LEN(FLT)) dut (
    .clk60MHz(clk60MHz), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .busy(busy),
    .rx_inhibit(rx_inhibit), .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe));

  initial begin
    clk60MHz = 1'b0;
    forever #5 clk60MHz = ~clk60MHz;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, overlap = 0;
  int last_done_cyc = -1, err_cyc = -1, err_doe = 7, busy_after_err = 7;
  int last_acc_cyc = -1, rts_cyc = -1;
  int inh_run = 0, last_inh_len = -1, inh_phases = 0;
  bit chk_busy_next = 0;
  logic prev_clk_oe = 1'b0;

  always @(posedge clk60MHz) cyc <= cyc + 1;

  always @(negedge clk60MHz) begin
    if (tx_done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (tx_err) begin
      err_cnt       <= err_cnt + 1;
      err_cyc       <= cyc;
      err_doe       <= int'(ps2_data_oe);
      chk_busy_next <= 1'b1;
    end else if (chk_busy_next) begin
      busy_after_err <= int'(busy);
      chk_busy_next  <= 1'b0;
    end
    if (tx_done && tx_err) overlap <= overlap + 1;
    if (tx_valid && tx_ready) last_acc_cyc <= cyc;
    if (ps2_clk_oe) inh_run <= inh_run + 1;
    else if (prev_clk_oe) begin
      last_inh_len <= inh_run;
      inh_phases   <= inh_phases + 1;
      inh_run      <= 0;
    end
    if (!ps2_clk_oe && ps2_data_oe && prev_clk_oe) rts_cyc <= cyc;
    prev_clk_oe <= ps2_clk_oe;
  end

  // ---------------- device model ----------------
  // mode 0: ACK, 1: NACK, 2: never clocks, 3: bench drives the clock by hand
  int         dev_mode = 0;
  int         dev_rises = 0;
  bit         dev_busy = 0;
  logic [9:0] cap;
  logic [9:0] dev_frames[$];

  initial begin
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    cap          = '0;
    forever begin
      @(negedge clk60MHz);
      if (dev_mode < 2 && rst && ps2_clk_line && !ps2_data_line) begin
        dev_busy  = 1;
        dev_rises = 0;
        repeat (H) @(negedge clk60MHz);
        for (int i = 1; i <= 12; i++) begin
          dev_clk_low = 1'b1;
          repeat (H) @(negedge clk60MHz);
          dev_clk_low = 1'b0;
          dev_rises   = i;
          if (i <= 10) cap[i-1] = ps2_data_line;
          if (i == 10) dev_frames.push_back(cap);
          if (i == 11 && dev_mode == 0) dev_data_low = 1'b1;
          if (i == 12) dev_data_low = 1'b0;
          repeat (H) @(negedge clk60MHz);
        end
        dev_busy = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d};
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk60MHz);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk60MHz);
    tx_valid = 1'b0;
  endtask

  task automatic wait_result(input int d0, input int e0, input int budget, input string tag);
    int w;
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < budget) begin
      @(negedge clk60MHz); #1;
      w++;
    end
    check({tag, " result within budget"}, int'(w < budget), 1);
  endtask

  task automatic wait_dev_idle(input string tag);
    int w;
    w = 0;
    while (dev_busy && w < BUD) begin
      @(negedge clk60MHz); #1;
      w++;
    end
    check({tag, " device idle"}, int'(dev_busy), 0);
  endtask

  task automatic do_xfer(input logic [7:0] d, input int mode, input logic [9:0] exp_frame,
                         input int exp_done, input int exp_err, input string tag);
    int d0, e0, p0, n0, exp_ph;
    dev_mode = mode;
    d0 = done_cnt; e0 = err_cnt; p0 = inh_phases; n0 = dev_frames.size();
    exp_ph = (mode == 1) ? ATTEMPTS : 1;
    send(d);
    #1;
    check({tag, " accepted"}, int'(busy), 1);
    wait_result(d0, e0, BUD, tag);
    wait_dev_idle(tag);
    repeat (5) @(negedge clk60MHz);
    #1;
    check({tag, " done pulses"}, done_cnt - d0, exp_done);
    check({tag, " err pulses"}, err_cnt - e0, exp_err);
    check({tag, " inhibit cycles"}, last_inh_len, INH_CYC);
    check({tag, " inhibit phases"}, inh_phases - p0, exp_ph);
    check({tag, " frame bits"},
          (dev_frames.size() > n0) ? int'(dev_frames[dev_frames.size()-1]) : -1,
          int'(exp_frame));
    check({tag, " lines released"}, int'({ps2_clk_oe, ps2_data_oe}), 0);
    check({tag, " busy after"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    int         mode;
    logic [9:0] frame;
    int         done;
    int         err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int d0, e0, p0, n0, first_done, w;
    logic [7:0] rd;
    int rm;

    vecs[0] = '{8'hF4, 0, 10'b1_0_1111_0100, 1, 0};
    vecs[1] = '{8'hFF, 0, 10'b1_1_1111_1111, 1, 0};
    vecs[2] = '{8'h00, 0, 10'b1_1_0000_0000, 1, 0};
    vecs[3] = '{8'hA5, 1, 10'b1_1_1010_0101, 0, 1};
    vecs[4] = '{8'h01, 0, 10'b1_0_0000_0001, 1, 0};

    rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; glitch_low = 1'b0;
    repeat (3) @(negedge clk60MHz);
    #1;
    check("reset tx_ready", int'(tx_ready), 1);
    check("reset busy", int'(busy), 0);
    check("reset rx_inhibit", int'(rx_inhibit), 0);
    check("reset oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    check("reset pulses", int'({tx_done, tx_err}), 0);
    @(negedge clk60MHz);
    rst = 1'b1;
    repeat (5) @(negedge clk60MHz);

    for (int i = 0; i < 5; i++)
      do_xfer(vecs[i].data, vecs[i].mode, vecs[i].frame, vecs[i].done, vecs[i].err,
              $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      rm = int'($urandom_range(0, 1));
      do_xfer(rd, rm, model_frame(rd), (rm == 0) ? 1 : 0, (rm == 1) ? 1 : 0,
              $sformatf("rand%0d_%02h", i, rd));
    end

    // back-to-back with tx_valid held; the data change while busy must be ignored
    dev_mode = 0;
    d0 = done_cnt; e0 = err_cnt; n0 = dev_frames.size();
    @(negedge clk60MHz);
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(negedge clk60MHz);
    tx_data = 8'h00;
    #1;
    check("b2b first accepted", int'(busy), 1);
    wait_result(d0, e0, BUD, "b2b first");
    first_done = last_done_cyc;
    @(negedge clk60MHz);
    @(negedge clk60MHz);
    tx_valid = 1'b0;
    #1;
    check("b2b second accept cycle", last_acc_cyc - first_done, 1);
    check("b2b second busy", int'(busy), 1);
    wait_result(d0 + 1, e0, BUD, "b2b second");
    wait_dev_idle("b2b");
    repeat (5) @(negedge clk60MHz);
    #1;
    check("b2b done pulses", done_cnt - d0, 2);
    check("b2b err pulses", err_cnt - e0, 0);
    check("b2b frame FF", (dev_frames.size() > n0) ? int'(dev_frames[n0]) : -1,
          int'(10'b1_1_1111_1111));
    check("b2b frame 00", (dev_frames.size() > n0 + 1) ? int'(dev_frames[n0+1]) : -1,
          int'(10'b1_1_0000_0000));

    // device never clocks: timeout measured from the last RTS entry
    dev_mode = 2;
    d0 = done_cnt; e0 = err_cnt; p0 = inh_phases;
    send(8'hA5);
    wait_result(d0, e0, ATTEMPTS * (TO_CYC + INH_CYC + 50) + 100, "timeout");
    repeat (3) @(negedge clk60MHz);
    #1;
    check("timeout latency", err_cyc - rts_cyc, TO_CYC);
    check("timeout data_oe at err", err_doe, 0);
    check("timeout busy next cycle", busy_after_err, 0);
    check("timeout err pulses", err_cnt - e0, 1);
    check("timeout done pulses", done_cnt - d0, 0);
    check("timeout inhibit phases", inh_phases - p0, ATTEMPTS);

    // asynchronous reset mid-shift
    dev_mode = 0;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    w = 0;
    while (!(dev_busy && dev_rises == 4) && w < BUD) begin
      @(negedge clk60MHz); #1;
      w++;
    end
    check("rst reached bit 4", int'(w < BUD), 1);
    #2 rst = 1'b0;
    #1;
    check("rst async oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    check("rst async busy", int'(busy), 0);
    check("rst async tx_ready", int'(tx_ready), 1);
    repeat (3) @(negedge clk60MHz);
    rst = 1'b1;
    wait_dev_idle("rst");
    repeat (20) @(negedge clk60MHz);
    #1;
    check("rst no pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    check("rst busy after", int'(busy), 0);

    // hand-clocked glitch test: 3-cycle low ignored, 10-cycle low gives one fall
    dev_mode = 3;
    d0 = done_cnt; e0 = err_cnt;
    send(8'h01);
    w = 0;
    while (!(busy && !ps2_clk_oe) && w < 1000) begin
      @(negedge clk60MHz); #1;
      w++;
    end
    check("glitch reached RTS", int'(w < 1000), 1);
    repeat (30) @(negedge clk60MHz);
    #1;
    check("glitch start bit", int'(ps2_data_oe), 1);
    @(negedge clk60MHz);
    glitch_low = 1'b1;
    repeat (3) @(negedge clk60MHz);
    glitch_low = 1'b0;
    repeat (30) @(negedge clk60MHz);
    #1;
    check("glitch 3cyc no advance", int'(ps2_data_oe), 1);
    @(negedge clk60MHz);
    glitch_low = 1'b1;
    repeat (10) @(negedge clk60MHz);
    glitch_low = 1'b0;
    repeat (30) @(negedge clk60MHz);
    #1;
    check("glitch 10cyc one advance", int'(ps2_data_oe), 0);
    check("glitch still busy", int'(busy), 1);
    wait_result(d0, e0, ATTEMPTS * (TO_CYC + INH_CYC + 50) + 100, "glitch");
    repeat (3) @(negedge clk60MHz);
    #1;
    check("glitch err pulses", err_cnt - e0, 1);
    check("glitch done pulses", done_cnt - d0, 0);

    check("done/err overlap", overlap, 0);
    dev_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the transmit direction complementing the MouseCtl receive path on the same ps2_clk/ps2_data pair.
- Sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse: clock inhibit, request-to-send, device-clocked shift-out of 8 data + odd parity + stop, ACK check.
- Sits beside MouseCtl in top; top forms the open-drain inouts from the *_oe outputs; rx_inhibit tells the receive path to ignore the line during a transfer.

Parameters:
- CLK_FREQ_HZ, 60_000_000, system clock frequency.
- INHIBIT_US, 100, clock-low inhibit time before RTS; INHIBIT_CYC = CLK_FREQ_HZ/1_000_000*INHIBIT_US (6000).
- TIMEOUT_CYC, 900_000, max clk60MHz cycles (15 ms) between consecutive device clock falling edges or while waiting for idle.
- FILTER_LEN, 8, consecutive equal samples needed to accept a new ps2_clk_in/ps2_data_in level.

Ports:
- clk60MHz  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tx_data  in  8  command byte
- tx_valid  in  1  request; byte accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- tx_done  out  1  one-cycle pulse: byte ACKed, bus idle
- tx_err  out  1  one-cycle pulse: NACK or timeout
- busy  out  1  high in every state except IDLE
- rx_inhibit  out  1  equals busy; receive path discards bits while high
- ps2_clk_in  in  1  raw ps2_clk level (async)
- ps2_data_in  in  1  raw ps2_data level (async)
- ps2_clk_oe  out  1  1 = pull ps2_clk low, 0 = release (Z)
- ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release (Z)

Behaviour:
- Inputs: 2-FF synchronizer, then FILTER_LEN glitch filter; filtered clock reset value 1. fall = filtered clock 1->0, one-cycle strobe.
- Reset (async, any state): state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, busy=0, tx_ready=1, counters 0. Lines released immediately, not at next edge.
- IDLE: tx_ready=1. On accept, latch tx_data into shift reg, compute parity = ~^tx_data, -> INHIBIT next cycle.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYC cycles; ps2_data_oe=0 in all but the last cycle, where ps2_data_oe=1. -> RTS.
- RTS: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); bit index k=0; timeout counter cleared. -> SHIFT.
- SHIFT: on each fall, k+1; k=1..8 drive data bit k-1 (LSB first), k=9 parity, k=10 stop (release). Drive rule: ps2_data_oe = ~bit. On fall with k=10 already sent -> ACK.
- ACK: on next fall sample filtered data: 0 = ACK, 1 = NACK; ps2_data_oe=0. -> WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock and data are both 1. Then pulse tx_done (ACK) or tx_err (NACK) for one cycle. -> IDLE.
- Timeout: 20-bit counter, cleared on entry to RTS and on every fall; in RTS/SHIFT/ACK/WAIT_IDLE, reaching TIMEOUT_CYC releases both lines the same cycle, pulses tx_err, and returns to IDLE.
- tx_done/tx_err never high together. Neither pulses after reset.
- tx_valid is ignored while busy. A request held across the done/err pulse is accepted in the first IDLE cycle after the pulse.
- fall during INHIBIT is ignored. The device cannot clock while the line is held low; a glitch there has no effect.

Optional Feature:
- PS2_TX_RETRY_EN:
  - Defined: on NACK or timeout, restart from INHIBIT with the latched byte, up to 2 retries (3 attempts total). No tx_err pulse on intermediate failures; tx_err pulses only after the 3rd failure. tx_done pulses on any successful attempt. The retry counter clears on accept and on reset.
  - Undefined: single attempt; the first failure pulses tx_err.

Test Plan:
- Send 0xF4; device model clocks at 12.5 kHz and ACKs -> ps2_clk_oe high exactly 6000 cycles; sampled bits 0,0,1,0,1,1,1,1, parity 0, stop 1; tx_done one pulse; tx_err 0; both oe 0 afterward.
- Send 0xFF then 0x00 back-to-back with tx_valid held -> parity 1 for both; second byte accepted the cycle after the first tx_done; two tx_done pulses.
- Device leaves data high in the ACK slot -> tx_err one pulse after lines idle; no tx_done. With PS2_TX_RETRY_EN: 3 INHIBIT phases, then a single tx_err.
- Device never clocks after RTS -> tx_err exactly 900_000 cycles after RTS entry; ps2_data_oe drops that same cycle; busy 0 next cycle.
- Assert rst low after the 4th data bit -> both oe 0 and busy 0 with no clock edge; tx_ready 1; no done/err pulse after release.
- 3-cycle low glitch on ps2_clk_in during SHIFT -> no bit advance. A subsequent 10-cycle low pulse -> exactly one advance.
